// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbiter
//  Purpose  : Shares the 16-cycle SDRAM cycle engine between a ROM-loader
//             byte-write port and two 32-bit read ports (CPU / video).
//             Runs the init dummy cycles after reset and forces keep-alive
//             dummy reads after the bus has been idle for REFRESH_PERIOD.
//  Ports    : clk, reset_n        - engine clock, async active-low reset
//             ld_req/addr/data    - loader write request (held until ld_ack)
//             ld_ack              - one-clock write-complete pulse
//             pN_req/addr         - read request (held until pN_ack)
//             pN_data/pN_ack      - {word1,word0} and its one-clock pulse
//             sdr_addr/we/rd/di   - request to the cycle engine
//             sdr_cycle/sdr_dq    - engine cycle counter and data sample
//             init_done           - init dummy cycles complete
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int INIT_CYCLES    = 85000,
    parameter int REFRESH_PERIOD = 1000,
    parameter int RD_CYC0        = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld_req,
    input  logic [24:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ack,
    input  logic        p1_req,
    input  logic [24:0] p1_addr,
    output logic [31:0] p1_data,
    output logic        p1_ack,
    input  logic        p2_req,
    input  logic [24:0] p2_addr,
    output logic [31:0] p2_data,
    output logic        p2_ack,
    output logic [24:0] sdr_addr,
    output logic        sdr_we,
    output logic        sdr_rd,
    output logic [7:0]  sdr_di,
    input  logic [4:0]  sdr_cycle,
    input  logic [15:0] sdr_dq,
    output logic        init_done
);

    localparam logic [4:0]  C_RD_W0    = 5'(RD_CYC0);
    localparam logic [4:0]  C_RD_W1    = 5'(RD_CYC0 + 1);
    localparam logic [4:0]  C_LAST     = 5'd15;
    localparam logic [16:0] C_INIT_CNT = 17'(INIT_CYCLES);
    localparam logic [15:0] C_REFRESH  = 16'(REFRESH_PERIOD);

    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_RUN = 2'd2} state_t;
    typedef enum logic [1:0] {GNT_DUMMY = 2'd0, GNT_LD = 2'd1, GNT_P1 = 2'd2, GNT_P2 = 2'd3} gnt_t;

    state_t      r_state,       w_state_nxt;
    gnt_t        r_gnt,         w_gnt_nxt;
    logic [16:0] r_init_cnt,    w_init_cnt_nxt;
    logic [15:0] r_refresh_tmr, w_refresh_tmr_nxt;
    logic        r_p2_turn,     w_p2_turn_nxt;   // 1: p2 wins a p1/p2 tie
    logic [24:0] r_sdr_addr,    w_sdr_addr_nxt;
    logic        r_sdr_we,      w_sdr_we_nxt;
    logic        r_sdr_rd,      w_sdr_rd_nxt;
    logic [7:0]  r_sdr_di,      w_sdr_di_nxt;
    logic        r_ld_ack,      w_ld_ack_nxt;
    logic        r_p1_ack,      w_p1_ack_nxt;
    logic        r_p2_ack,      w_p2_ack_nxt;
    logic [31:0] r_p1_data,     w_p1_data_nxt;
    logic [31:0] r_p2_data,     w_p2_data_nxt;
    logic        r_init_done,   w_init_done_nxt;

    logic        w_cyc0;
    logic        w_refresh_due;
    logic [16:0] w_cnt_inc;
    logic        w_launch;
    gnt_t        w_launch_gnt;
    logic        w_unused_addr_lsb;

    assign w_cyc0            = (sdr_cycle == 5'd0);
    assign w_refresh_due     = (r_refresh_tmr == C_REFRESH);
    assign w_cnt_inc         = r_init_cnt + 17'd1;
    // Read ports fetch aligned 16-bit word pairs; the byte-address LSB is dropped.
    assign w_unused_addr_lsb = p1_addr[0] ^ p2_addr[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_INIT;
            r_gnt         <= GNT_DUMMY;
            r_init_cnt    <= '0;
            r_refresh_tmr <= '0;
            r_p2_turn     <= 1'b0;
            r_sdr_addr    <= '0;
            r_sdr_we      <= 1'b0;
            r_sdr_rd      <= 1'b0;
            r_sdr_di      <= '0;
            r_ld_ack      <= 1'b0;
            r_p1_ack      <= 1'b0;
            r_p2_ack      <= 1'b0;
            r_p1_data     <= '0;
            r_p2_data     <= '0;
            r_init_done   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_init_cnt    <= w_init_cnt_nxt;
            r_refresh_tmr <= w_refresh_tmr_nxt;
            r_p2_turn     <= w_p2_turn_nxt;
            r_sdr_addr    <= w_sdr_addr_nxt;
            r_sdr_we      <= w_sdr_we_nxt;
            r_sdr_rd      <= w_sdr_rd_nxt;
            r_sdr_di      <= w_sdr_di_nxt;
            r_ld_ack      <= w_ld_ack_nxt;
            r_p1_ack      <= w_p1_ack_nxt;
            r_p2_ack      <= w_p2_ack_nxt;
            r_p1_data     <= w_p1_data_nxt;
            r_p2_data     <= w_p2_data_nxt;
            r_init_done   <= w_init_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_gnt_nxt         = r_gnt;
        w_init_cnt_nxt    = r_init_cnt;
        w_refresh_tmr_nxt = r_refresh_tmr;
        w_p2_turn_nxt     = r_p2_turn;
        w_sdr_addr_nxt    = r_sdr_addr;
        w_sdr_we_nxt      = r_sdr_we;
        w_sdr_rd_nxt      = r_sdr_rd;
        w_sdr_di_nxt      = r_sdr_di;
        w_ld_ack_nxt      = 1'b0;
        w_p1_ack_nxt      = 1'b0;
        w_p2_ack_nxt      = 1'b0;
        w_p1_data_nxt     = r_p1_data;
        w_p2_data_nxt     = r_p2_data;
        w_init_done_nxt   = r_init_done;
        w_launch          = 1'b0;
        w_launch_gnt      = GNT_DUMMY;

        case (r_state)
            // Also covers a reset taken mid-cycle: wait for the engine to
            // finish its own cycle before the first dummy launch.
            ST_INIT: w_launch = w_cyc0;

            ST_IDLE: begin
                if (w_cyc0) begin
                    if (w_refresh_due) begin
                        w_launch = 1'b1;
                    end else if (ld_req) begin
                        w_launch     = 1'b1;
                        w_launch_gnt = GNT_LD;
                    end else if (p1_req && (!p2_req || !r_p2_turn)) begin
                        w_launch     = 1'b1;
                        w_launch_gnt = GNT_P1;
                    end else if (p2_req) begin
                        w_launch     = 1'b1;
                        w_launch_gnt = GNT_P2;
                    end
                end
                if (!w_launch && !w_refresh_due) begin
                    w_refresh_tmr_nxt = r_refresh_tmr + 16'd1;
                end
            end

            ST_RUN: begin
                if (sdr_cycle == C_RD_W0) begin
                    if (r_gnt == GNT_P1) w_p1_data_nxt[15:0] = sdr_dq;
                    if (r_gnt == GNT_P2) w_p2_data_nxt[15:0] = sdr_dq;
                end
                if (sdr_cycle == C_RD_W1) begin
                    if (r_gnt == GNT_P1) w_p1_data_nxt[31:16] = sdr_dq;
                    if (r_gnt == GNT_P2) w_p2_data_nxt[31:16] = sdr_dq;
                end
                // Dropping the request here means the engine sees it low at
                // its next cycle 0 and does not restart on its own.
                if (sdr_cycle == C_LAST) begin
                    w_sdr_we_nxt = 1'b0;
                    w_sdr_rd_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                    case (r_gnt)
                        GNT_LD:  w_ld_ack_nxt = 1'b1;
                        GNT_P1:  w_p1_ack_nxt = 1'b1;
                        GNT_P2:  w_p2_ack_nxt = 1'b1;
                        default: begin
                            // Dummy cycles count only while initialising;
                            // afterwards they are keep-alive refreshes.
                            if (!r_init_done) begin
                                w_init_cnt_nxt = w_cnt_inc;
                                if (w_cnt_inc == C_INIT_CNT) begin
                                    w_init_done_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = ST_INIT;
                                end
                            end
                        end
                    endcase
                end
            end

            default: w_state_nxt = ST_INIT;
        endcase

        if (w_launch) begin
            w_state_nxt       = ST_RUN;
            w_gnt_nxt         = w_launch_gnt;
            w_refresh_tmr_nxt = '0;
            w_sdr_we_nxt      = (w_launch_gnt == GNT_LD);
            w_sdr_rd_nxt      = (w_launch_gnt != GNT_LD);
            w_sdr_addr_nxt    = '0;
            w_sdr_di_nxt      = '0;
            case (w_launch_gnt)
                GNT_LD: begin
                    w_sdr_addr_nxt = ld_addr;
                    w_sdr_di_nxt   = ld_data;
                end
                GNT_P1: begin
                    w_sdr_addr_nxt = {p1_addr[24:1], 1'b0};
                    w_p2_turn_nxt  = 1'b1;
                end
                GNT_P2: begin
                    w_sdr_addr_nxt = {p2_addr[24:1], 1'b0};
                    w_p2_turn_nxt  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sdr_addr  = r_sdr_addr;
    assign sdr_we    = r_sdr_we;
    assign sdr_rd    = r_sdr_rd;
    assign sdr_di    = r_sdr_di;
    assign ld_ack    = r_ld_ack;
    assign p1_ack    = r_p1_ack;
    assign p2_ack    = r_p2_ack;
    assign p1_data   = r_p1_data;
    assign p2_data   = r_p2_data;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arbiter
//  Purpose  : Self-checking bench for sdram_arbiter with a cycle-engine model
//             and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;
    localparam int INIT_N = 4;
    localparam int RP     = 20;
    localparam int RC0    = 7;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld_req  = 1'b0;
    logic [24:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_ack;
    logic        p1_req  = 1'b0;
    logic [24:0] p1_addr = '0;
    logic [31:0] p1_data;
    logic        p1_ack;
    logic        p2_req  = 1'b0;
    logic [24:0] p2_addr = '0;
    logic [31:0] p2_data;
    logic        p2_ack;
    logic [24:0] sdr_addr;
    logic        sdr_we;
    logic        sdr_rd;
    logic [7:0]  sdr_di;
    logic [15:0] sdr_dq;
    logic        init_done;

    // cycle engine model
    logic [4:0]  eng_cyc = 5'd0;
    logic [15:0] eng_w0  = '0;
    logic [15:0] eng_w1  = '0;
    logic        fix_dq  = 1'b0;
    logic [15:0] fix_w0  = '0;
    logic [15:0] fix_w1  = '0;

    int n_cmp  = 0;
    int n_fail = 0;
    int tick   = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.INIT_CYCLES(INIT_N), .REFRESH_PERIOD(RP), .RD_CYC0(RC0)) dut (
        .clk(clk), .reset_n(reset_n),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ack(p1_ack),
        .p2_req(p2_req), .p2_addr(p2_addr), .p2_data(p2_data), .p2_ack(p2_ack),
        .sdr_addr(sdr_addr), .sdr_we(sdr_we), .sdr_rd(sdr_rd), .sdr_di(sdr_di),
        .sdr_cycle(eng_cyc), .sdr_dq(sdr_dq), .init_done(init_done)
    );

    // Engine: starts a cycle when it sees a request at cycle 0, then runs 1..15 -> 0.
    always @(posedge clk) begin
        if (eng_cyc == 5'd0) begin
            if (sdr_rd || sdr_we) begin
                eng_cyc <= 5'd1;
                eng_w0  <= fix_dq ? fix_w0 : 16'($urandom);
                eng_w1  <= fix_dq ? fix_w1 : 16'($urandom);
            end
        end else begin
            eng_cyc <= (eng_cyc == 5'd15) ? 5'd0 : eng_cyc + 5'd1;
        end
    end
    assign sdr_dq = (eng_cyc == 5'(RC0))     ? eng_w0 :
                    (eng_cyc == 5'(RC0 + 1)) ? eng_w1 : {11'h5A5, eng_cyc};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy    = 1'b0;
    bit          m_done    = 1'b0;
    int          m_kind    = 0;     // 0 dummy, 1 loader, 2 p1, 3 p2
    int          m_cnt     = 0;     // completed init dummy cycles
    int          m_idle    = 0;     // idle clocks since last launch (saturating)
    bit          m_last_p2 = 1'b1;  // p2 "served last" => p1 wins first tie
    logic [24:0] m_addr    = '0;
    logic [7:0]  m_di      = '0;
    logic [31:0] m_p1      = '0;
    logic [31:0] m_p2      = '0;
    bit          m_lda = 1'b0, m_p1a = 1'b0, m_p2a = 1'b0;
    logic [4:0]  pre_cyc   = '0;    // engine cycle the DUT saw at the last edge
    logic [15:0] pre_dq    = '0;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_kind = 0; m_cnt = 0; m_idle = 0; m_last_p2 = 1;
        m_addr = '0; m_di = '0; m_p1 = '0; m_p2 = '0; m_lda = 0; m_p1a = 0; m_p2a = 0;
    endtask

    task automatic model_step();
        int k;
        m_lda = 0; m_p1a = 0; m_p2a = 0;
        if (!m_busy) begin
            k = -1;
            if (pre_cyc == 5'd0) begin
                if (!m_done)                                 k = 0;
                else if (m_idle >= RP)                       k = 0;
                else if (ld_req)                             k = 1;
                else if (p1_req && (!p2_req || m_last_p2))   k = 2;
                else if (p2_req)                             k = 3;
            end
            if (k >= 0) begin
                m_busy = 1; m_kind = k; m_idle = 0; m_di = '0;
                case (k)
                    1: begin m_addr = ld_addr; m_di = ld_data; end
                    2: begin m_addr = p1_addr & ~25'd1; m_last_p2 = 0; end
                    3: begin m_addr = p2_addr & ~25'd1; m_last_p2 = 1; end
                    default: m_addr = '0;
                endcase
            end else if (m_done && m_idle < RP) begin
                m_idle++;
            end
        end else begin
            if (pre_cyc == 5'(RC0)) begin
                if (m_kind == 2) m_p1[15:0] = pre_dq;
                if (m_kind == 3) m_p2[15:0] = pre_dq;
            end
            if (pre_cyc == 5'(RC0 + 1)) begin
                if (m_kind == 2) m_p1[31:16] = pre_dq;
                if (m_kind == 3) m_p2[31:16] = pre_dq;
            end
            if (pre_cyc == 5'd15) begin
                m_busy = 0;
                case (m_kind)
                    1: m_lda = 1;
                    2: m_p1a = 1;
                    3: m_p2a = 1;
                    default: if (!m_done) begin
                        m_cnt++;
                        if (m_cnt == INIT_N) m_done = 1;
                    end
                endcase
            end
        end
    endtask

    // ---------------- event log ----------------
    bit          prev_act  = 1'b0;
    bit          prev_done = 1'b0;
    int          launch_t[$];
    bit          launch_we[$];
    logic [24:0] launch_addr[$];
    logic [7:0]  launch_di[$];
    int          ack_t[$];
    int          ack_port[$];   // 0 loader, 1 p1, 2 p2
    int          done_t = -1;

    // compare process: advance model by one edge, check every output
    always @(negedge clk) begin
        tick++;
        if (!reset_n) model_reset();
        else          model_step();
        check("sdr_rd",    32'(sdr_rd),    32'(m_busy && m_kind != 1));
        check("sdr_we",    32'(sdr_we),    32'(m_busy && m_kind == 1));
        check("sdr_addr",  32'(sdr_addr),  32'(m_addr));
        check("sdr_di",    32'(sdr_di),    32'(m_di));
        check("ld_ack",    32'(ld_ack),    32'(m_lda));
        check("p1_ack",    32'(p1_ack),    32'(m_p1a));
        check("p2_ack",    32'(p2_ack),    32'(m_p2a));
        check("p1_data",   p1_data,        m_p1);
        check("p2_data",   p2_data,        m_p2);
        check("init_done", 32'(init_done), 32'(m_done));
        if ((sdr_rd || sdr_we) && !prev_act) begin
            launch_t.push_back(tick);  launch_we.push_back(sdr_we);
            launch_addr.push_back(sdr_addr); launch_di.push_back(sdr_di);
        end
        if (ld_ack) begin ack_t.push_back(tick); ack_port.push_back(0); end
        if (p1_ack) begin ack_t.push_back(tick); ack_port.push_back(1); end
        if (p2_ack) begin ack_t.push_back(tick); ack_port.push_back(2); end
        if (init_done && !prev_done) done_t = tick;
        prev_act  = sdr_rd || sdr_we;
        prev_done = init_done;
        pre_cyc   = eng_cyc;
        pre_dq    = sdr_dq;
    end

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input int port, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nclk();
            if ((port == 0 && ld_ack) || (port == 1 && p1_ack) || (port == 2 && p2_ack)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_init(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            nclk();
            if (init_done) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        bit ok;
        int idx, n0, t_rst;

        // reset state
        reset_n = 1'b0;
        repeat (3) nclk();
        check("rst_rd",   32'(sdr_rd),    32'd0);
        check("rst_addr", 32'(sdr_addr),  32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_p1d",  p1_data,        32'd0);

        // init: p1 held throughout must not be served before init_done
        p1_addr = 25'h0000040;
        p1_req  = 1'b1;
        reset_n = 1'b1;
        wait_init("init_done_seen");
        check("init_launches", 32'(launch_t.size()), 32'd4);
        for (int i = 0; i < launch_t.size(); i++) begin
            check("init_addr", 32'(launch_addr[i]), 32'd0);
            check("init_we",   32'(launch_we[i]),   32'd0);
        end
        check("init_spacing", 32'(launch_t[1] - launch_t[0]), 32'd17);
        check("init_done_time", 32'(done_t - launch_t[3]), 32'd16);
        check("init_no_ack", 32'(ack_t.size()), 32'd0);
        wait_ack(1, 100, ok);
        p1_req = 1'b0;
        check("p1_after_init", 32'(ok), 32'd1);
        check("p1_ack_after_done", 32'(ack_t[0] > done_t), 32'd1);

        // loader write
        idx = launch_t.size();
        ld_addr = 25'h0012345; ld_data = 8'hA5; ld_req = 1'b1;
        wait_ack(0, 100, ok);
        ld_req = 1'b0;
        check("ld_ack_seen",  32'(ok), 32'd1);
        check("ld_launches",  32'(launch_t.size() - idx), 32'd1);
        check("ld_we",        32'(launch_we[idx]), 32'd1);
        check("ld_addr",      32'(launch_addr[idx]), 32'h0012345);
        check("ld_di",        32'(launch_di[idx]), 32'hA5);
        check("ld_ack_delay", 32'(ack_t[ack_t.size() - 1] - launch_t[idx]), 32'd16);

        // reads with known bus data
        fix_dq = 1'b1; fix_w0 = 16'h1122; fix_w1 = 16'h3344;
        p1_addr = 25'h0000100; p1_req = 1'b1;
        wait_ack(1, 100, ok);
        p1_req = 1'b0;
        check("p1_rd_ack", 32'(ok), 32'd1);
        check("p1_rd_data", p1_data, 32'h33441122);
        fix_w0 = 16'hAAAA; fix_w1 = 16'h5555;
        idx = launch_t.size();
        p2_addr = 25'h0000201; p2_req = 1'b1;
        wait_ack(2, 100, ok);
        p2_req = 1'b0;
        check("p2_rd_ack",   32'(ok), 32'd1);
        check("p2_addr_lsb", 32'(launch_addr[idx]), 32'h200);
        check("p2_rd_data",  p2_data, 32'h5555AAAA);
        check("p1_data_held", p1_data, 32'h33441122);
        fix_dq = 1'b0;

        // both read ports held: grants alternate, 17 clocks apart
        idx = ack_t.size();
        p1_req = 1'b1; p2_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            nclk();
            if (ack_t.size() >= idx + 4) break;
        end
        p1_req = 1'b0; p2_req = 1'b0;
        check("alt_count", 32'(ack_t.size() >= idx + 4), 32'd1);
        for (int k = 0; k < 4; k++) check("alt_port", 32'(ack_port[idx + k]), (k % 2 == 0) ? 32'd1 : 32'd2);
        for (int k = 1; k < 4; k++) check("alt_spacing", 32'(ack_t[idx + k] - ack_t[idx + k - 1]), 32'd17);

        // all three on the same clock: loader, then p1, then p2
        idx = ack_t.size();
        ld_addr = 25'h1ABCDEF; ld_data = 8'h3C; p1_addr = 25'h0000400; p2_addr = 25'h0000800;
        ld_req = 1'b1; p1_req = 1'b1; p2_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            nclk();
            if (ld_ack) ld_req = 1'b0;
            if (p1_ack) p1_req = 1'b0;
            if (p2_ack) p2_req = 1'b0;
            if (!ld_req && !p1_req && !p2_req) break;
        end
        check("tri_ld", 32'(ack_port[idx]),     32'd0);
        check("tri_p1", 32'(ack_port[idx + 1]), 32'd1);
        check("tri_p2", 32'(ack_port[idx + 2]), 32'd2);

        // idle: keep-alive dummy reads every RP+17 clocks, no acks
        idx = launch_t.size(); n0 = ack_t.size();
        repeat (140) nclk();
        check("rf_no_ack",   32'(ack_t.size() - n0), 32'd0);
        check("rf_count",    32'(launch_t.size() - idx >= 3), 32'd1);
        check("rf_first",    32'(launch_t[idx] - ack_t[n0 - 1]), 32'd21);
        check("rf_spacing1", 32'(launch_t[idx + 1] - launch_t[idx]), 32'd37);
        check("rf_spacing2", 32'(launch_t[idx + 2] - launch_t[idx + 1]), 32'd37);
        check("rf_addr",     32'(launch_addr[idx + 1]), 32'd0);
        check("rf_we",       32'(launch_we[idx + 1]), 32'd0);

        // reset mid-cycle at engine cycle 5
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            nclk();
            if (eng_cyc == 5'd5) begin ok = 1'b1; break; end
        end
        check("rst_cyc5_seen", 32'(ok), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rd",   32'(sdr_rd),    32'd0);
        check("mid_rst_addr", 32'(sdr_addr),  32'd0);
        check("mid_rst_done", 32'(init_done), 32'd0);
        check("mid_rst_p1d",  p1_data,        32'd0);
        check("mid_rst_p2d",  p2_data,        32'd0);
        t_rst = tick;
        idx = launch_t.size();
        nclk(); nclk();
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            nclk();
            if (launch_t.size() > idx) break;
        end
        check("relaunch_seen",  32'(launch_t.size() > idx), 32'd1);
        check("relaunch_delay", 32'(launch_t[idx] - t_rst), 32'd12);
        wait_init("reinit_done");

        // randomized traffic
        n0 = ack_t.size();
        for (int c = 0; c < 3000; c++) begin
            nclk();
            if (ld_req && (ld_ack || $urandom_range(0, 63) == 0)) ld_req = 1'b0;
            else if (!ld_req && $urandom_range(0, 39) == 0) begin
                ld_req = 1'b1; ld_addr = 25'($urandom); ld_data = 8'($urandom);
            end
            if (p1_req && (p1_ack || $urandom_range(0, 63) == 0)) p1_req = 1'b0;
            else if (!p1_req && $urandom_range(0, 5) == 0) begin
                p1_req = 1'b1; p1_addr = 25'($urandom);
            end
            if (p2_req && (p2_ack || $urandom_range(0, 63) == 0)) p2_req = 1'b0;
            else if (!p2_req && $urandom_range(0, 5) == 0) begin
                p2_req = 1'b1; p2_addr = 25'($urandom);
            end
        end
        ld_req = 1'b0; p1_req = 1'b0; p2_req = 1'b0;
        repeat (40) nclk();
        check("rand_activity", 32'(ack_t.size() - n0 > 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Sequences and shares the single-port 16-cycle SDRAM cycle engine between three requesters: one ROM-loader byte-write port and two 32-bit read ports (CPU and video). After reset it runs the init dummy cycles. When the bus has been idle for a set time it inserts keep-alive refresh cycles, because the engine only auto-refreshes inside a started cycle. It sits between the loader/CPU/video logic and the SDRAM cycle engine's addr/we/rd/di/sm_cycle interface.

Parameters:
INIT_CYCLES, 85000, dummy cycles issued after reset before init_done
REFRESH_PERIOD, 1000, idle clocks after which a keep-alive cycle is forced
RD_CYC0, 7, sdr_cycle value at which the first burst word is sampled from sdr_dq; second word at RD_CYC0+1

Ports:
clk  in  1  SDRAM clock; the engine's clock
reset_n  in  1  asynchronous active-low reset
ld_req  in  1  loader write request; hold with ld_addr/ld_data stable until ld_ack
ld_addr  in  25  loader byte address
ld_data  in  8  loader write byte
ld_ack  out  1  one-clock pulse: write cycle complete
p1_req  in  1  read port 1 request; hold until p1_ack
p1_addr  in  25  read port 1 byte address (bit 0 ignored)
p1_data  out  32  read data {word1, word0}; valid from p1_ack, held until next p1_ack
p1_ack  out  1  one-clock pulse: p1_data valid
p2_req, p2_addr, p2_data, p2_ack  same as port 1
sdr_addr  out  25  address to engine
sdr_we  out  1  write request to engine
sdr_rd  out  1  read request to engine
sdr_di  out  8  write byte to engine
sdr_cycle  in  5  engine cycle counter (0 = idle/first, 15 = last)
sdr_dq  in  16  SDRAM data bus sample
init_done  out  1  high once init dummy cycles are complete

Behaviour:
- One clock domain. reset_n is asynchronous, active-low. Every output is registered.
- Reset values: all outputs 0, including sdr_addr, sdr_di, p1_data, p2_data and init_done. State=INIT, init counter=0, refresh timer=0, round-robin pointer=port 1.
- States: INIT, IDLE, RUN.
- Launching a cycle: a cycle is launched only on a clock where sdr_cycle==0. On that clock the block registers sdr_rd or sdr_we high and latches sdr_addr and sdr_di. sdr_we and sdr_rd are never high together. Address and data stay constant for the whole cycle.
- In RUN, on sdr_cycle==RD_CYC0: capture sdr_dq into word0 of the granted port's data register. On RD_CYC0+1: capture into word1. Both captures happen only for read grants.
- In RUN, on sdr_cycle==15: clear sdr_we/sdr_rd, pulse the granted port's ack next clock, go to IDLE. The engine therefore sees the request low at its next cycle 0 and does not restart. Minimum spacing between launches is 17 clocks.
- INIT state:
  - Issue back-to-back dummy read cycles (sdr_rd=1, sdr_addr=0), using the same launch/end rules.
  - Count completed cycles, 17-bit counter. When the count reaches INIT_CYCLES, set init_done=1 and enter IDLE.
  - Requests are ignored during INIT: no acks, no data change.
- IDLE grant priority (evaluated only when sdr_cycle==0):
  1. refresh_due: dummy read, no ack.
  2. ld_req: write.
  3. p1_req / p2_req round-robin. If both are pending, grant the port not served last. If only one is pending, grant it. The pointer updates only on read grants.
- Refresh timer (16-bit): cleared on every launch. Otherwise increments in IDLE, saturating at REFRESH_PERIOD. refresh_due = (timer==REFRESH_PERIOD).
- The loader may starve the read ports. This is intended, since loading happens with the CPU held.
- If a request drops before its ack, the cycle still completes and the ack still pulses; the requester ignores it.
- Reset mid-cycle: outputs clear immediately. After reset, INIT waits for sdr_cycle==0 before its first launch, because the engine finishes its cycle on its own.

Test Plan:
- Init (INIT_CYCLES=4): release reset with the engine model idle → exactly 4 sdr_rd cycles with addr 0, then init_done=1 one clock after the 4th cycle ends. A p1_req held during init gets no ack until after init_done.
- Loader write (ld_addr=0x0012345, ld_data=0xA5) → sdr_we=1, sdr_addr=0x0012345, sdr_di=0xA5 for sdr_cycle 0..15, sdr_rd=0, ld_ack one pulse after cycle 15.
- Read (p1_addr=0x0000100; model drives sdr_dq=0x1122 at RD_CYC0 and 0x3344 at RD_CYC0+1) → p1_data=0x33441122 at p1_ack, held through a later p2 read.
- p1_req and p2_req both held continuously for 4 cycles → grants alternate p1,p2,p1,p2, with launches 17 clocks apart.
- ld_req, p1_req and p2_req asserted on the same clock → loader served first, then p1, then p2. No cycle launches while sdr_cycle!=0.
- Refresh (REFRESH_PERIOD=20): idle after init_done → dummy sdr_rd every 20+17 clocks, no acks. Pulse reset_n low at sdr_cycle==5 → outputs 0 immediately; first relaunch occurs only after the model's sdr_cycle returns to 0.
